// File: rtl/sw_loop_sched.sv
// ---------------------------------------------------------------------------
// sw_loop_sched
//   Round-robin scheduler interleaving NT copies of a guarded counting loop.
//   Each thread owns a counter X and a program location PC (L0..L6). At most
//   one thread advances one loop step per granted cycle; the others hold.
//   A sticky violation flag rises when any thread reaches the error location
//   L6.
//
//   Ports
//     clk      in   1     clock, rising edge
//     rst_n    in   1     asynchronous reset, active low
//     start    in   1     one-cycle pulse; (re)initialises threads, begins run
//     stall    in   1     1 = no grant this cycle, all state holds
//     grant    out  NT    one-hot grant of the thread stepped last cycle
//     busy     out  1     scheduler running
//     done     out  1     run finished (no thread left to step)
//     viol     out  1     sticky; some thread has reached L6
//     x_flat   out  NT*W  thread i's X at [i*W +: W]
//     pc_flat  out  NT*3  thread i's PC at [i*3 +: 3]
//     steps    out  16    granted steps since start, saturating
// ---------------------------------------------------------------------------

// Per-thread loop state. Steps only when the scheduler selects it.
module sw_loop_thread #(
    parameter int W     = 6,
    parameter int KINIT = 0,
    parameter int KINC  = 3,
    parameter int KCOND = 17,
    parameter int KPROP = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         step,
    output logic [W-1:0] x,
    output logic [2:0]   pc,
    output logic         req,
    output logic         err
);
    localparam logic [W-1:0] X_INIT = W'(KINIT);
    localparam logic [W-1:0] X_INC  = W'(KINC);
    // Bounds compared at 32 bits so a bound >= 2^W still reads as "always below".
    localparam logic [31:0]  COND_B = 32'(KCOND);
    localparam logic [31:0]  PROP_B = 32'(KPROP);

    localparam logic [2:0] L0 = 3'd0;
    localparam logic [2:0] L1 = 3'd1;
    localparam logic [2:0] L2 = 3'd2;
    localparam logic [2:0] L3 = 3'd3;
    localparam logic [2:0] L4 = 3'd4;
    localparam logic [2:0] L5 = 3'd5;
    localparam logic [2:0] L6 = 3'd6;

    logic lt_cond, lt_prop;
    assign lt_cond = 32'(x) < COND_B;
    assign lt_prop = 32'(x) < PROP_B;

    // L5 (exit) and L6 (error) are terminal: they never request a step.
    assign req = (pc != L5) && (pc != L6);
    assign err = (pc == L6);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x  <= X_INIT;
            pc <= L0;
        end else if (init) begin
            x  <= X_INIT;
            pc <= L0;
        end else if (step) begin
            case (pc)
                L0: pc <= L1;
                L1: begin
                    if (lt_prop) begin
                        x  <= x + X_INC;
                        pc <= L2;
                    end else begin
                        pc <= L6;
                    end
                end
                L2: pc <= L3;
                L3: pc <= lt_cond ? L1 : L4;
                L4: pc <= lt_prop ? L5 : L6;
                default: pc <= pc;
            endcase
        end
    end
endmodule

module sw_loop_sched #(
    parameter int NT    = 2,
    parameter int W     = 6,
    parameter int KINIT = 0,
    parameter int KINC  = 3,
    parameter int KCOND = 17,
    parameter int KPROP = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    output logic [NT-1:0]   grant,
    output logic            busy,
    output logic            done,
    output logic            viol,
    output logic [NT*W-1:0] x_flat,
    output logic [NT*3-1:0] pc_flat,
    output logic [15:0]     steps
);
    localparam int PW = (NT > 1) ? $clog2(NT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state;
    logic [PW-1:0]           ptr;
    logic [NT-1:0]           req, err, step_vec, sel_oh;
    logic [NT-1:0][W-1:0]    x_q;
    logic [NT-1:0][2:0]      pc_q;
    logic                    sel_vld;
    logic [PW-1:0]           sel_idx;
    logic                    fire, init;

    // A start only re-initialises when not already running.
    assign init = start && (state != S_RUN);
    assign fire = (state == S_RUN) && !stall && sel_vld;

    // Round-robin pick: first requester at or after ptr, wrapping.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NT; k++) begin
            if (!sel_vld && req[(int'(ptr) + k) % NT]) begin
                sel_vld = 1'b1;
                sel_idx = PW'((int'(ptr) + k) % NT);
            end
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NT; i++)
            sel_oh[i] = (sel_idx == PW'(i));
    end

    assign step_vec = sel_oh & {NT{fire}};

    generate
        for (genvar i = 0; i < NT; i++) begin : g_thr
            sw_loop_thread #(
                .W(W), .KINIT(KINIT), .KINC(KINC), .KCOND(KCOND), .KPROP(KPROP)
            ) u_thr (
                .clk  (clk),
                .rst_n(rst_n),
                .init (init),
                .step (step_vec[i]),
                .x    (x_q[i]),
                .pc   (pc_q[i]),
                .req  (req[i]),
                .err  (err[i])
            );
        end
    endgenerate

    // Packed arrays lay element i out at [i*W +: W] / [i*3 +: 3].
    assign x_flat  = x_q;
    assign pc_flat = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ptr   <= '0;
            grant <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            viol  <= 1'b0;
            steps <= '0;
        end else begin
            // viol tracks PC one cycle late and stays up until the next start.
            viol <= viol | (|err);
            case (state)
                S_RUN: begin
                    grant <= '0;
                    if (!stall) begin
                        if (!sel_vld) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            grant <= sel_oh;
                            ptr   <= (sel_idx == PW'(NT - 1)) ? '0 : sel_idx + 1'b1;
                            if (steps != 16'hFFFF)
                                steps <= steps + 16'd1;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        ptr   <= '0;
                        steps <= '0;
                        viol  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sw_loop_sched.sv
module tb_sw_loop_sched;
    localparam int NT = 2, W = 6, KINIT = 0, KINC = 3, KCOND = 17, KPROP = 19;

    logic clk, rst_n, start, stall;
    logic [NT-1:0]   grant;
    logic            busy, done, viol;
    logic [NT*W-1:0] x_flat;
    logic [NT*3-1:0] pc_flat;
    logic [15:0]     steps;

    // Second instance: single thread starting at 16, which runs into L6.
    logic       start2, stall2;
    logic [0:0] grant2;
    logic       busy2, done2, viol2;
    logic [5:0] x2;
    logic [2:0] pc2;
    logic [15:0] steps2;

    sw_loop_sched #(.NT(NT), .W(W), .KINIT(KINIT), .KINC(KINC), .KCOND(KCOND), .KPROP(KPROP)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .grant(grant),
        .busy(busy), .done(done), .viol(viol), .x_flat(x_flat), .pc_flat(pc_flat), .steps(steps));

    sw_loop_sched #(.NT(1), .W(6), .KINIT(16), .KINC(3), .KCOND(17), .KPROP(19)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stall(stall2), .grant(grant2),
        .busy(busy2), .done(done2), .viol(viol2), .x_flat(x2), .pc_flat(pc2), .steps(steps2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (behavioural, per thread traces) ------
    int          m_x[NT], m_pc[NT];
    int          m_ptr, m_steps;
    logic [NT-1:0] m_grant;
    bit          m_viol, m_running, m_finished;

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin m_x[i] = KINIT; m_pc[i] = 0; end
        m_ptr = 0; m_steps = 0; m_grant = '0;
        m_viol = 0; m_running = 0; m_finished = 0;
    endtask

    task automatic step_thread(input int i);
        case (m_pc[i])
            0: m_pc[i] = 1;
            1: if (m_x[i] < KPROP) begin
                   m_x[i] = (m_x[i] + KINC) % (1 << W);
                   m_pc[i] = 2;
               end else m_pc[i] = 6;
            2: m_pc[i] = 3;
            3: m_pc[i] = (m_x[i] < KCOND) ? 1 : 4;
            4: m_pc[i] = (m_x[i] < KPROP) ? 5 : 6;
            default: ;
        endcase
    endtask

    task automatic model_step(input logic st, input logic sl);
        bit nv;
        int pick, j;
        nv = m_viol;
        for (int i = 0; i < NT; i++) if (m_pc[i] == 6) nv = 1;
        m_grant = '0;
        if (m_running) begin
            if (!sl) begin
                pick = -1;
                for (int k = 0; k < NT; k++) begin
                    j = (m_ptr + k) % NT;
                    if (pick < 0 && m_pc[j] != 5 && m_pc[j] != 6) pick = j;
                end
                if (pick < 0) begin
                    m_running = 0; m_finished = 1;
                end else begin
                    step_thread(pick);
                    m_grant[pick] = 1'b1;
                    m_ptr = (pick + 1) % NT;
                    if (m_steps < 65535) m_steps++;
                end
            end
        end else if (st) begin
            for (int i = 0; i < NT; i++) begin m_x[i] = KINIT; m_pc[i] = 0; end
            m_ptr = 0; m_steps = 0; m_running = 1; m_finished = 0; nv = 0;
        end
        m_viol = nv;
    endtask

    task automatic check_all();
        logic [NT*W-1:0] ex;
        logic [NT*3-1:0] ep;
        for (int i = 0; i < NT; i++) begin
            ex[i*W +: W] = W'(m_x[i]);
            ep[i*3 +: 3] = 3'(m_pc[i]);
        end
        chk("grant", 64'(grant), 64'(m_grant));
        chk("busy", 64'(busy), 64'(m_running));
        chk("done", 64'(done), 64'(m_finished));
        chk("viol", 64'(viol), 64'(m_viol));
        chk("steps", 64'(steps), 64'(m_steps));
        chk("x_flat", 64'(x_flat), 64'(ex));
        chk("pc_flat", 64'(pc_flat), 64'(ep));
    endtask

    // One clock: model consumes the inputs present at the edge, outputs checked 1 later.
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(start, stall);
        #1;
        check_all();
    endtask

    // ---------------- vector table for full runs ----------------------------
    typedef struct {
        int stall_at;
        int stall_len;
        int start_at;
        int exp_cyc;   // edges from start edge until done is seen
    } run_vec_t;

    run_vec_t vecs[5];

    // u2 expected trace, index 0 = just after the start edge
    int exp_pc2[7]   = '{0, 1, 2, 3, 4, 6, 6};
    int exp_x2[7]    = '{16, 16, 19, 19, 19, 19, 19};
    int exp_g2[7]    = '{0, 1, 1, 1, 1, 1, 0};
    int exp_done2[7] = '{0, 0, 0, 0, 0, 0, 1};
    int exp_viol2[7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        vecs[0] = '{0, 0, 0, 41};
        vecs[1] = '{10, 5, 0, 46};
        vecs[2] = '{1, 3, 0, 44};
        vecs[3] = '{41, 2, 0, 43};
        vecs[4] = '{0, 0, 20, 41};

        rst_n = 1'b0; start = 1'b0; stall = 1'b0; start2 = 1'b0; stall2 = 1'b0;
        model_reset();
        #12;
        // T1 reset state
        check_all();
        chk("u2_reset_x", 64'(x2), 64'd16);
        chk("u2_reset_pc", 64'(pc2), 64'd0);
        chk("u2_reset_busy", 64'(busy2), 64'd0);
        rst_n = 1'b1;
        repeat (2) cyc();

        // T4 single thread into the error location
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) cyc();
            chk("u2_pc", 64'(pc2), 64'(exp_pc2[k]));
            chk("u2_x", 64'(x2), 64'(exp_x2[k]));
            chk("u2_grant", 64'(grant2), 64'(exp_g2[k]));
            chk("u2_done", 64'(done2), 64'(exp_done2[k]));
            chk("u2_viol", 64'(viol2), 64'(exp_viol2[k]));
        end
        chk("u2_steps", 64'(steps2), 64'd5);
        chk("u2_busy_end", 64'(busy2), 64'd0);

        // T5 asynchronous reset mid-run
        start = 1'b1; cyc(); start = 1'b0;
        repeat (15) cyc();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("u2_async_done", 64'(done2), 64'd0);
        chk("u2_async_pc", 64'(pc2), 64'd0);
        repeat (2) cyc();
        #2 rst_n = 1'b1;
        repeat (3) cyc();
        chk("idle_after_reset", 64'(busy), 64'd0);

        // T2/T3/T6 full runs from IDLE, then repeatedly from DONE
        for (int v = 0; v < 5; v++) begin
            int cnt;
            cnt = 0;
            start = 1'b1; cyc(); start = 1'b0;
            chk("run_start_busy", 64'(busy), 64'd1);
            chk("run_start_steps", 64'(steps), 64'd0);
            for (int c = 1; c <= 200; c++) begin
                stall = (c >= vecs[v].stall_at) && (c < vecs[v].stall_at + vecs[v].stall_len);
                start = (c == vecs[v].start_at);
                cyc();
                if (done) begin cnt = c; break; end
            end
            stall = 1'b0; start = 1'b0;
            chk("run_cycles", 64'(cnt), 64'(vecs[v].exp_cyc));
            chk("run_steps", 64'(steps), 64'd40);
            chk("run_x", 64'(x_flat), 64'({6'd18, 6'd18}));
            chk("run_pc", 64'(pc_flat), 64'({3'd5, 3'd5}));
            chk("run_viol", 64'(viol), 64'd0);
            cyc();
        end

        // Randomised stall/start traffic against the model
        for (int n = 0; n < 1500; n++) begin
            stall = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 60) == 0);
            cyc();
        end
        stall = 1'b0; start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
